// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - request/response bus and SPI pins of the SPI master sequencer
//
// Ports (signals):
//   req_valid/req_ready/req_rw/req_addr/req_wdata  request handshake from the requester
//   rsp_valid/rsp_rdata                            one-cycle response strobe and read data
//   busy                                           controller not in IDLE
//   sclk/cs/mosi/miso                              SPI pins towards the slave
// Modports: master = requester plus SPI slave side, slave = spi_master_ctrl.
interface spi_master_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, miso,
        input  req_ready, rsp_valid, rsp_rdata, busy, sclk, cs, mosi
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, miso,
        output req_ready, rsp_valid, rsp_rdata, busy, sclk, cs, mosi
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master sequencer: one 16-bit frame (addr7, rw, data8) per request
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     spi_master_ctrl_if.slave: request handshake, response strobe, busy, SPI pins
// Parameter CLK_DIV: clk cycles per sclk half-period (2..255).
module spi_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_master_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_div;
    logic [4:0]  r_bits;
    logic [15:0] r_tx;
    logic [7:0]  r_rx;
    logic        r_rw;
    logic        r_sclk;
    logic        r_cs;
    logic        r_mosi;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_rdata;

    logic        w_hs;
    logic        w_div_zero;
    logic        w_rise;
    logic        w_fall;
    logic        w_last_fall;
    logic [15:0] w_tx;

    assign w_hs        = (r_state == IDLE) && bus.req_valid;
    assign w_div_zero  = (r_div == 8'd0);
    // The edge that flips sclk is decided by the current (pre-toggle) level.
    assign w_rise      = (r_state == SHIFT) && w_div_zero && !r_sclk;
    assign w_fall      = (r_state == SHIFT) && w_div_zero && r_sclk;
    assign w_last_fall = w_fall && (r_bits == 5'd16);
    // Reads send zeros in the data phase so the slave never sees stale write data.
    assign w_tx        = {bus.req_addr, bus.req_rw, bus.req_rw ? 8'h00 : bus.req_wdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_hs)        w_next = SETUP;
            SETUP:   if (w_div_zero)  w_next = SHIFT;
            SHIFT:   if (w_last_fall) w_next = HOLD;
            HOLD:    if (w_div_zero)  w_next = GAP;
            GAP:     if (w_div_zero)  w_next = IDLE;
            default:                  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div       <= 8'd0;
            r_bits      <= 5'd0;
            r_tx        <= 16'd0;
            r_rx        <= 8'd0;
            r_rw        <= 1'b0;
            r_sclk      <= 1'b0;
            r_cs        <= 1'b1;
            r_mosi      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (w_hs) begin
                    r_tx   <= w_tx;
                    r_rw   <= bus.req_rw;
                    r_cs   <= 1'b0;
                    r_mosi <= w_tx[15];
                    r_div  <= DIV_RELOAD;
                    r_bits <= 5'd0;
                    r_rx   <= 8'd0;
                end
            end else begin
                // One shared half-period timer for SETUP, SHIFT, HOLD and GAP.
                r_div <= w_div_zero ? DIV_RELOAD : r_div - 8'd1;
            end

            if (w_rise) begin
                r_sclk <= 1'b1;
                r_rx   <= {r_rx[6:0], bus.miso};
                r_bits <= r_bits + 5'd1;
            end
            if (w_fall) begin
                r_sclk <= 1'b0;
                r_tx   <= {r_tx[14:0], 1'b0};
                r_mosi <= r_tx[14];
            end

            if ((r_state == HOLD) && w_div_zero) begin
                r_cs        <= 1'b1;
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= r_rw ? r_rx : 8'h00;
            end
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.sclk      = r_sclk;
    assign bus.cs        = r_cs;
    assign bus.mosi      = r_mosi;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - scoreboard bench for spi_master_ctrl (CLK_DIV=4 and CLK_DIV=2 builds)
module tb_spi_master_ctrl;

    localparam int D1 = 4;
    localparam int D2 = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_ctrl_if if1 ();
    spi_master_ctrl_if if2 ();

    spi_master_ctrl #(.CLK_DIV(D1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(if1));
    spi_master_ctrl #(.CLK_DIV(D2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard queues: expected mosi frame, expected rsp_rdata, miso byte the slave returns.
    logic [15:0] frame_q[$];
    logic [7:0]  rdata_q[$];
    logic [7:0]  miso_q[$];
    logic [15:0] frame2_q[$];
    logic [7:0]  rdata2_q[$];
    logic [7:0]  miso2_q[$];

    // Slave model, DUT1: 8 leading ones then the queued byte, MSB first, changed on sclk fall.
    logic [15:0] s1_tx, s1_rx;
    int          s1_bits = 0;
    logic        s1_pcs = 1'b1, s1_psclk = 1'b0;
    always @(if1.cs or if1.sclk) begin
        if (s1_pcs && !if1.cs) begin
            s1_bits = 0;
            s1_rx   = 16'd0;
            s1_tx   = 16'hFF00;
            if (miso_q.size() > 0) s1_tx[7:0] = miso_q.pop_front();
            if1.miso = s1_tx[15];
        end else if (!if1.cs && !s1_psclk && if1.sclk) begin
            s1_rx = {s1_rx[14:0], if1.mosi};
            s1_bits++;
        end else if (!if1.cs && s1_psclk && !if1.sclk) begin
            s1_tx = {s1_tx[14:0], 1'b0};
            if1.miso = s1_tx[15];
        end
        if (!s1_pcs && if1.cs && frame_q.size() > 0) begin
            check_eq("frame_mosi", s1_rx, frame_q.pop_front());
            check_eq("frame_bits", s1_bits, 16);
        end
        s1_pcs   = if1.cs;
        s1_psclk = if1.sclk;
    end

    // Slave model, DUT2.
    logic [15:0] s2_tx, s2_rx;
    int          s2_bits = 0;
    logic        s2_pcs = 1'b1, s2_psclk = 1'b0;
    always @(if2.cs or if2.sclk) begin
        if (s2_pcs && !if2.cs) begin
            s2_bits = 0;
            s2_rx   = 16'd0;
            s2_tx   = 16'hFF00;
            if (miso2_q.size() > 0) s2_tx[7:0] = miso2_q.pop_front();
            if2.miso = s2_tx[15];
        end else if (!if2.cs && !s2_psclk && if2.sclk) begin
            s2_rx = {s2_rx[14:0], if2.mosi};
            s2_bits++;
        end else if (!if2.cs && s2_psclk && !if2.sclk) begin
            s2_tx = {s2_tx[14:0], 1'b0};
            if2.miso = s2_tx[15];
        end
        if (!s2_pcs && if2.cs && frame2_q.size() > 0) begin
            check_eq("d2_frame_mosi", s2_rx, frame2_q.pop_front());
            check_eq("d2_frame_bits", s2_bits, 16);
        end
        s2_pcs   = if2.cs;
        s2_psclk = if2.sclk;
    end

    // Cycle monitors, sampled on the falling clk edge.
    int   ncyc = 0, hs_cyc = 0, prev_hs_cyc = 0, rsp_cyc = 0, n_rsp = 0;
    int   cs_low_run = 0, last_cs_low = 0, cs_high_run = 0, min_gap = 100000;
    int   n_frames = 0, bad_busy = 0;
    logic m_pcs = 1'b1;
    int   n_rsp2 = 0, cs2_low_run = 0, last_cs2_low = 0, last_rise2 = 0, sclk2_per = 0;
    logic m2_pcs = 1'b1, m2_psclk = 1'b0;
    always @(negedge clk) begin
        ncyc++;
        if (if1.req_valid && if1.req_ready && rst_n) begin
            prev_hs_cyc = hs_cyc;
            hs_cyc      = ncyc;
        end
        if (!if1.cs) begin
            if (m_pcs) begin
                if (n_frames > 0 && cs_high_run < min_gap) min_gap = cs_high_run;
                cs_low_run = 0;
            end
            cs_low_run++;
            if (if1.req_ready || !if1.busy) bad_busy++;
        end else begin
            if (!m_pcs) begin
                last_cs_low = cs_low_run;
                n_frames++;
                cs_high_run = 0;
            end
            cs_high_run++;
        end
        m_pcs = if1.cs;
        if (if1.rsp_valid) begin
            rsp_cyc = ncyc;
            n_rsp++;
            if (rdata_q.size() == 0) check_eq("rsp_unexpected", 1, 0);
            else                     check_eq("rsp_rdata", if1.rsp_rdata, rdata_q.pop_front());
        end

        if (!if2.cs) begin
            if (m2_pcs) cs2_low_run = 0;
            cs2_low_run++;
        end else if (!m2_pcs) begin
            last_cs2_low = cs2_low_run;
        end
        m2_pcs = if2.cs;
        if (if2.sclk && !m2_psclk) begin
            if (last_rise2 > 0) sclk2_per = ncyc - last_rise2;
            last_rise2 = ncyc;
        end
        m2_psclk = if2.sclk;
        if (if2.rsp_valid) begin
            n_rsp2++;
            if (rdata2_q.size() == 0) check_eq("d2_rsp_unexpected", 1, 0);
            else                      check_eq("d2_rsp_rdata", if2.rsp_rdata, rdata2_q.pop_front());
        end
    end

    // Drive one request on DUT1; exp=0 leaves the scoreboard untouched (aborted frame).
    task automatic send1(input logic rw, input logic [6:0] a, input logic [7:0] wd,
                         input logic [7:0] sd, input bit keep, input bit exp);
        int t;
        @(posedge clk); #1;
        if1.req_valid = 1'b1;
        if1.req_rw    = rw;
        if1.req_addr  = a;
        if1.req_wdata = wd;
        if (exp) begin
            frame_q.push_back({a, rw, rw ? 8'h00 : wd});
            rdata_q.push_back(rw ? sd : 8'h00);
            miso_q.push_back(sd);
        end
        t = 0;
        while (!if1.req_ready && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) check_eq("handshake_timeout", 0, 1);
        @(posedge clk); #1;
        if (!keep) if1.req_valid = 1'b0;
    endtask

    task automatic wait_rsp1(input int target);
        int t;
        t = 0;
        while (n_rsp < target && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 3000) check_eq("rsp_timeout", n_rsp, target);
    endtask

    initial begin
        int t;
        int rsp_before;
        if1.req_valid = 1'b0; if1.req_rw = 1'b0; if1.req_addr = 7'd0; if1.req_wdata = 8'd0;
        if2.req_valid = 1'b0; if2.req_rw = 1'b0; if2.req_addr = 7'd0; if2.req_wdata = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cs", if1.cs, 1);
        check_eq("rst_sclk", if1.sclk, 0);
        check_eq("rst_mosi", if1.mosi, 0);
        check_eq("rst_rsp_valid", if1.rsp_valid, 0);
        check_eq("rst_rsp_rdata", if1.rsp_rdata, 0);
        check_eq("rst_busy", if1.busy, 0);
        check_eq("rst_req_ready", if1.req_ready, 1);
        rst_n = 1'b1;

        // Write 2A <- 55: frame 0101010_0_01010101, cs low 136, rsp at cycle 137.
        send1(1'b0, 7'h2A, 8'h55, 8'hC3, 1'b0, 1'b1);
        wait_rsp1(1);
        check_eq("wr_cs_low_cycles", last_cs_low, 34 * D1);
        check_eq("wr_rsp_cycle", rsp_cyc - hs_cyc, 34 * D1 + 1);

        // Read 7F, slave returns A5.
        send1(1'b1, 7'h7F, 8'h99, 8'hA5, 1'b0, 1'b1);
        wait_rsp1(2);

        // Back-to-back with req_valid held high.
        send1(1'b0, 7'h01, 8'hF0, 8'h00, 1'b1, 1'b1);
        send1(1'b1, 7'h40, 8'h12, 8'h5E, 1'b0, 1'b1);
        check_eq("b2b_hs_after_rsp", hs_cyc - rsp_cyc, D1);
        check_eq("b2b_hs_spacing", hs_cyc - prev_hs_cyc, 35 * D1 + 1);
        wait_rsp1(4);
        check_eq("b2b_cs_gap_ge_div", min_gap >= D1, 1);

        // Request fields toggled while busy must not reach the frame.
        send1(1'b0, 7'h15, 8'hE7, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if1.req_addr  = 7'($urandom);
            if1.req_wdata = 8'($urandom);
        end
        wait_rsp1(5);

        // Reset after the 9th sclk rise; mosi is 1 there so the async clear is visible.
        send1(1'b0, 7'h33, 8'h8F, 8'h00, 1'b0, 1'b0);
        t = 0;
        while (s1_bits < 9 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) check_eq("rst9_timeout", s1_bits, 9);
        check_eq("pre_rst_mosi", if1.mosi, 1);
        rsp_before = n_rsp;
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_cs", if1.cs, 1);
        check_eq("midrst_sclk", if1.sclk, 0);
        check_eq("midrst_mosi", if1.mosi, 0);
        check_eq("midrst_busy", if1.busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check_eq("midrst_no_rsp", n_rsp, rsp_before);
        send1(1'b1, 7'h5A, 8'h00, 8'h6E, 1'b0, 1'b1);
        wait_rsp1(rsp_before + 1);
        check_eq("post_rst_cs_low_cycles", last_cs_low, 34 * D1);
        check_eq("busy_ready_in_frame", bad_busy, 0);

        // CLK_DIV=2 build: read 3C.
        @(posedge clk); #1;
        if2.req_valid = 1'b1; if2.req_rw = 1'b1; if2.req_addr = 7'h4C; if2.req_wdata = 8'hFF;
        frame2_q.push_back({7'h4C, 1'b1, 8'h00});
        rdata2_q.push_back(8'h3C);
        miso2_q.push_back(8'h3C);
        t = 0;
        while (!if2.req_ready && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1 if2.req_valid = 1'b0;
        t = 0;
        while (n_rsp2 < 1 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) check_eq("d2_rsp_timeout", n_rsp2, 1);
        check_eq("d2_cs_low_cycles", last_cs2_low, 34 * D2);
        check_eq("d2_sclk_period", sclk2_per, 2 * D2);

        repeat (20) @(posedge clk);
        check_eq("sb_frames_left", frame_q.size() + frame2_q.size(), 0);
        check_eq("sb_rsp_left", rdata_q.size() + rdata2_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
